// File: rtl/td_decoder_pkg.sv
// Shared definitions for the time-domain encoder/decoder pair.
// Holds the FSM state encoding and the code width and unit scaling that both sides use.
package td_decoder_pkg;

    localparam int DEF_BITS        = 3;
    localparam int DEF_UNIT        = 4;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/td_edge_sync.sv
// Synchronizer and rising-edge detector for one asynchronous edge input.
// Ports: clk, rst_n (sync, active-low), din (async in), pulse (one-cycle rise pulse).
module td_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
            last <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            last <= sync[SYNC_STAGES-1];
        end
    end

    assign pulse = sync[SYNC_STAGES-1] & ~last;

endmodule

// File: rtl/td_decoder.sv
// Time-domain decoder: measures the gap between start and stop edges in UNIT-cycle steps.
// Ports: clk, rst_n, tin_ref/tin_sig (async edges), dout/dout_valid/dout_ready, ovf, busy.
module td_decoder
    import td_decoder_pkg::*;
#(
    parameter int BITS        = DEF_BITS,
    parameter int UNIT        = DEF_UNIT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tin_ref,
    input  logic            tin_sig,
    output logic [BITS-1:0] dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            ovf,
    output logic            busy
);

    localparam int MAX = 2**BITS - 1;
    localparam int PW  = (UNIT > 1) ? $clog2(UNIT) : 1;

    localparam logic [PW-1:0]   PLAST = PW'(UNIT - 1);
    localparam logic [BITS-1:0] CMAX  = BITS'(MAX);

    logic ref_p;
    logic sig_p;

    state_t          state, state_nx;
    logic [PW-1:0]   presc, presc_nx;
    logic [BITS-1:0] cnt, cnt_nx;
    logic [BITS-1:0] dout_nx;
    logic            ovf_nx;
    logic            wrap;

    td_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (tin_ref),
        .pulse (ref_p)
    );

    td_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sig (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (tin_sig),
        .pulse (sig_p)
    );

    // In COUNT, {cnt,presc} holds k-1, so floor(k/UNIT) = cnt + wrap.
    assign wrap = (presc == PLAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            presc <= '0;
            cnt   <= '0;
            dout  <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            presc <= presc_nx;
            cnt   <= cnt_nx;
            dout  <= dout_nx;
            ovf   <= ovf_nx;
        end
    end

    always_comb begin
        state_nx = state;
        presc_nx = presc;
        cnt_nx   = cnt;
        dout_nx  = dout;
        ovf_nx   = ovf;
        unique case (state)
            IDLE: begin
                if (ref_p) begin
                    presc_nx = '0;
                    cnt_nx   = '0;
                    if (sig_p) begin
                        dout_nx  = '0;
                        ovf_nx   = 1'b0;
                        state_nx = DONE;
                    end else begin
                        state_nx = COUNT;
                    end
                end
            end
            COUNT: begin
                // Range end beats a coincident stop edge.
                if (wrap && (cnt == CMAX)) begin
                    dout_nx  = CMAX;
                    ovf_nx   = 1'b1;
                    state_nx = DONE;
                end else if (sig_p) begin
                    dout_nx  = cnt + BITS'(wrap);
                    ovf_nx   = 1'b0;
                    state_nx = DONE;
                end else if (wrap) begin
                    presc_nx = '0;
                    cnt_nx   = cnt + 1'b1;
                end else begin
                    presc_nx = presc + 1'b1;
                end
            end
            DONE: begin
                if (dout_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy       = (state == COUNT);
    assign dout_valid = (state == DONE);

endmodule
